// File: rtl/adder_arbiter_if.sv
// Request/response bundle between two operand producers and adder_arbiter.
// master = producer/consumer side, slave = arbiter side.
interface adder_arbiter_if;
    logic       req0_valid;
    logic [5:0] req0_a;
    logic [5:0] req0_b;
    logic       req0_ready;
    logic       req1_valid;
    logic [5:0] req1_a;
    logic [5:0] req1_b;
    logic       req1_ready;
    logic       rsp_valid;
    logic [5:0] rsp_sum;
    logic       rsp_id;
    logic       rsp_ovf;
    logic       rsp_ready;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_sum, rsp_id, rsp_ovf,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_sum, rsp_id, rsp_ovf,
        input  rsp_ready
    );
endinterface

// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one adder6b; IDLE/ADD/RESP sequencing.
// Define ADDARB_OVF_EN to build the registered carry-out on rsp_ovf.
module adder6b (
    input  logic [5:0] a,
    input  logic [5:0] b,
    output logic [5:0] sum,
    output logic       cout
);
    logic [6:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[5:0];
    assign cout = full[6];
endmodule

module adder_arbiter #(
    parameter int RR_EN = 1
) (
    input logic            clk,
    input logic            rst_n,
    adder_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic [5:0] op_a;
    logic [5:0] op_b;
    logic       op_id;
    logic       last_id;
    logic [5:0] sum_q;
    logic       id_q;

    logic [5:0] add_sum;
    logic       add_cout;

    logic       any_req;
    logic       both_req;
    logic       gnt_id;
    logic       grant;

    adder6b u_add (
        .a    (op_a),
        .b    (op_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Tie goes to the requester that did not win last (RR) or to 0 (fixed).
    always_comb begin
        both_req = bus.req0_valid & bus.req1_valid;
        any_req  = bus.req0_valid | bus.req1_valid;
        if (both_req) begin
            gnt_id = (RR_EN != 0) ? ~last_id : 1'b0;
        end else begin
            gnt_id = ~bus.req0_valid;
        end
        grant = rst_n & (state == IDLE) & any_req;
    end

    assign bus.req0_ready = grant & ~gnt_id;
    assign bus.req1_ready = grant & gnt_id;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_sum    = sum_q;
    assign bus.rsp_id     = id_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            op_id   <= 1'b0;
            last_id <= 1'b1;
            sum_q   <= '0;
            id_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        op_a    <= gnt_id ? bus.req1_a : bus.req0_a;
                        op_b    <= gnt_id ? bus.req1_b : bus.req0_b;
                        op_id   <= gnt_id;
                        last_id <= gnt_id;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    sum_q <= add_sum;
                    id_q  <= op_id;
                    state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDARB_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == ADD) begin
            ovf_q <= add_cout;
        end
    end

    assign bus.rsp_ovf = ovf_q;
`else
    logic unused_cout;

    assign unused_cout = add_cout;
    assign bus.rsp_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: round-robin and fixed-priority
// instances driven by directed then randomized traffic.
module tb_adder_arbiter;
    localparam int NCYC = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       id;
        logic [5:0] sum;
        logic       ovf;
    } exp_t;

    task automatic chk(input string name, input int mode,
                       input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s mode=%0d got=%0h want=%0h t=%0t",
                     name, mode, act, req, $time);
        end
    endtask

    function automatic exp_t ref_add(input logic id, input logic [5:0] a,
                                     input logic [5:0] b);
        int   s;
        exp_t e;
        s     = int'(a) + int'(b);
        e.id  = id;
        e.sum = 6'(s % 64);
`ifdef ADDARB_OVF_EN
        e.ovf = (s >= 64);
`else
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [5:0] rnd6();
        if ($urandom_range(0, 7) == 0) return 6'h3F;
        return 6'($urandom_range(0, 63));
    endfunction

    // g = 1: round-robin instance, g = 0: fixed-priority instance
    for (genvar g = 0; g < 2; g++) begin : m
        logic rst_n;
        adder_arbiter_if bus ();

        adder_arbiter #(.RR_EN(g)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        exp_t q[$];
        bit   seen0 = 1'b0;
        bit   seen1 = 1'b0;

        // stimulus
        initial begin
            logic [5:0] a0, b0, a1, b1;
            bit         v0, v1;
            a0 = 6'h05; b0 = 6'h0A; a1 = 6'h3F; b1 = 6'h02;
            v0 = 1'b1;  v1 = 1'b1;
            rst_n = 1'b0;
            bus.rsp_ready = 1'b1;
            bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
            bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
            for (int n = 0; n < NCYC; n++) begin
                @(posedge clk);
                #1;
                if (v0 && seen0) begin
                    a0 = rnd6(); b0 = rnd6();
                    v0 = (n < 24) || ($urandom_range(0, 3) != 0);
                end else if (v0 && n >= 24 && $urandom_range(0, 15) == 0) begin
                    v0 = 1'b0;
                end else if (!v0 && n >= 24 && $urandom_range(0, 1) == 1) begin
                    v0 = 1'b1; a0 = rnd6(); b0 = rnd6();
                end
                if (v1 && seen1) begin
                    a1 = rnd6(); b1 = rnd6();
                    v1 = (n < 24) || ($urandom_range(0, 3) != 0);
                end else if (v1 && n >= 24 && $urandom_range(0, 15) == 0) begin
                    v1 = 1'b0;
                end else if (!v1 && n >= 24 && $urandom_range(0, 1) == 1) begin
                    v1 = 1'b1; a1 = rnd6(); b1 = rnd6();
                end
                if (n < 2 || n == 23) rst_n = 1'b0;
                else if (n >= 24) rst_n = ($urandom_range(0, 59) != 0);
                else rst_n = 1'b1;
                if (n < 14) bus.rsp_ready = 1'b1;
                else if (n < 21) bus.rsp_ready = 1'b0;
                else if (n < 24) bus.rsp_ready = 1'b1;
                else bus.rsp_ready = ($urandom_range(0, 3) != 0);
                bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
                bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
            end
        end

        // reference model: timing and arbitration rules, pushes expectations
        initial begin
            int cyc, gcyc, w;
            bit pend, last, was_rst, ev;
            cyc = 0; gcyc = 0; pend = 1'b0; last = 1'b1; was_rst = 1'b1;
            @(posedge clk);
            forever begin
                @(negedge clk);
                if (was_rst) begin
                    chk("rst_valid", g, 8'(bus.rsp_valid), 8'd0);
                    chk("rst_sum", g, 8'(bus.rsp_sum), 8'd0);
                    chk("rst_id", g, 8'(bus.rsp_id), 8'd0);
                    chk("rst_ovf", g, 8'(bus.rsp_ovf), 8'd0);
                end
                ev = pend && (cyc >= gcyc + 2);
                chk("rsp_valid", g, 8'(bus.rsp_valid), 8'(ev));
                w = -1;
                if (rst_n && !pend) begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        if (g == 1) w = last ? 0 : 1;
                        else w = 0;
                    end else if (bus.req0_valid) begin
                        w = 0;
                    end else if (bus.req1_valid) begin
                        w = 1;
                    end
                end
                chk("req0_ready", g, 8'(bus.req0_ready), 8'(w == 0));
                chk("req1_ready", g, 8'(bus.req1_ready), 8'(w == 1));
                seen0 = (bus.req0_ready === 1'b1);
                seen1 = (bus.req1_ready === 1'b1);
                if (!rst_n) begin
                    pend = 1'b0;
                    last = 1'b1;
                    q.delete();
                end else begin
                    if (ev && bus.rsp_ready) pend = 1'b0;
                    if (w == 0) q.push_back(ref_add(1'b0, bus.req0_a, bus.req0_b));
                    if (w == 1) q.push_back(ref_add(1'b1, bus.req1_a, bus.req1_b));
                    if (w >= 0) begin
                        pend = 1'b1;
                        gcyc = cyc;
                        last = (w == 1);
                    end
                end
                was_rst = !rst_n;
                cyc++;
            end
        end

        // monitor: compares presented responses against the queue head
        initial begin
            @(posedge clk);
            forever begin
                @(negedge clk);
                if (rst_n && bus.rsp_valid === 1'b1) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected mode=%0d got=valid want=none t=%0t",
                                 g, $time);
                    end else begin
                        chk("rsp_id", g, 8'(bus.rsp_id), 8'(q[0].id));
                        chk("rsp_sum", g, 8'(bus.rsp_sum), 8'(q[0].sum));
                        chk("rsp_ovf", g, 8'(bus.rsp_ovf), 8'(q[0].ovf));
                        if (bus.rsp_ready === 1'b1) void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        repeat (NCYC + 10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
